// File: rtl/riscv_pkg.sv
// Shared branch-unit definitions: B-type funct3 codes, resolver FSM states,
// result payload and next-PC helper.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned F3_W = 3;

  localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
  localparam logic [F3_W-1:0] F3_BNE  = 3'b001;
  localparam logic [F3_W-1:0] F3_BLT  = 3'b100;
  localparam logic [F3_W-1:0] F3_BGE  = 3'b101;
  localparam logic [F3_W-1:0] F3_BLTU = 3'b110;
  localparam logic [F3_W-1:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_RESP = 2'd2
  } br_state_t;

  typedef struct packed {
    logic            taken;
    logic            illegal;
    logic            misalign;
    logic [XLEN-1:0] target;
  } br_res_t;

  // Taken branches go to pc+imm, others fall through; bit 0 is never a valid PC bit.
  function automatic logic [XLEN-1:0] next_pc(input logic            taken,
                                               input logic [XLEN-1:0] pc,
                                               input logic [XLEN-1:0] imm);
    logic [XLEN-1:0] t;
    t    = taken ? (pc + imm) : (pc + XLEN'(4));
    t[0] = 1'b0;
    return t;
  endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// Request/result handshake, comparator link and statistics of the branch resolver.
interface branch_resolve_if
  import riscv_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);

  logic             req_valid;
  logic             req_ready;
  logic [F3_W-1:0]  req_funct3;
  logic [XLEN-1:0]  req_pc;
  logic [XLEN-1:0]  req_imm;

  logic             BrUn;
  logic             BrEq;
  logic             BrLT;

  logic             res_valid;
  logic             res_ready;
  logic             res_taken;
  logic [XLEN-1:0]  res_target;
  logic             res_illegal;
  logic             res_misalign;
  logic             PCSel;
  logic             flush;

  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] taken_cnt;

  // Pipeline/comparator side
  modport master (
    output req_valid, req_funct3, req_pc, req_imm, BrEq, BrLT, res_ready,
    input  req_ready, BrUn, res_valid, res_taken, res_target, res_illegal,
           res_misalign, PCSel, flush, branch_cnt, taken_cnt
  );

  // Branch resolver side
  modport slave (
    input  req_valid, req_funct3, req_pc, req_imm, BrEq, BrLT, res_ready,
    output req_ready, BrUn, res_valid, res_taken, res_target, res_illegal,
           res_misalign, PCSel, flush, branch_cnt, taken_cnt
  );

endinterface

// File: rtl/branch_decide.sv
// Combinational funct3 + comparator-flag decode into taken / illegal.
module branch_decide
  import riscv_pkg::*;
(
  input  logic [F3_W-1:0] funct3,
  input  logic            br_eq,
  input  logic            br_lt,
  output logic            taken_c,
  output logic            illegal_c
);

  always_comb begin
    taken_c   = 1'b0;
    illegal_c = 1'b0;
    case (funct3)
      F3_BEQ:           taken_c = br_eq;
      F3_BNE:           taken_c = !br_eq;
      F3_BLT, F3_BLTU:  taken_c = br_lt;
      F3_BGE, F3_BGEU:  taken_c = !br_lt;
      default:          illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolver: accepts a B-type branch, drives the comparator for one
// cycle, then presents a held result (taken, target, flags) until consumed.
module branch_resolve
  import riscv_pkg::*;
#(
  parameter int unsigned CNT_W = 16
)
(
  input  logic            clk,
  input  logic            rst,
  branch_resolve_if.slave bus
);

  br_state_t        state_q, state_n;
  logic [F3_W-1:0]  funct3_q, funct3_n;
  logic [XLEN-1:0]  pc_q, pc_n;
  logic [XLEN-1:0]  imm_q, imm_n;
  br_res_t          res_q, res_n;
  logic             ready_q, ready_n;
  logic             brun_q, brun_n;
  logic             valid_q, valid_n;
  logic             pcsel_q, pcsel_n;
  logic             flush_q, flush_n;
  logic [CNT_W-1:0] bcnt_q, bcnt_n;
  logic [CNT_W-1:0] tcnt_q, tcnt_n;

  logic             taken_c;
  logic             illegal_c;

  branch_decide u_decide (
    .funct3    (funct3_q),
    .br_eq     (bus.BrEq),
    .br_lt     (bus.BrLT),
    .taken_c   (taken_c),
    .illegal_c (illegal_c)
  );

  // Next-state and next-output logic; every output is a flop loaded from here
  always_comb begin
    state_n  = state_q;
    funct3_n = funct3_q;
    pc_n     = pc_q;
    imm_n    = imm_q;
    res_n    = res_q;
    bcnt_n   = bcnt_q;
    tcnt_n   = tcnt_q;
    flush_n  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_n  = ST_CMP;
          funct3_n = bus.req_funct3;
          pc_n     = bus.req_pc;
          imm_n    = bus.req_imm;
        end
      end
      ST_CMP: begin
        // Comparator flags are live this cycle; fold them straight into the result
        state_n          = ST_RESP;
        res_n.taken      = taken_c;
        res_n.illegal    = illegal_c;
        res_n.target     = next_pc(taken_c, pc_q, imm_q);
        res_n.misalign   = taken_c & res_n.target[1];
      end
      ST_RESP: begin
        if (bus.res_ready) begin
          state_n = ST_IDLE;
          bcnt_n  = bcnt_q + CNT_W'(1);
          if (res_q.taken) begin
            tcnt_n  = tcnt_q + CNT_W'(1);
            flush_n = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    ready_n = (state_n == ST_IDLE);
    brun_n  = (state_n == ST_CMP) & funct3_n[1];
    valid_n = (state_n == ST_RESP);
    pcsel_n = valid_n & res_n.taken;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      funct3_q <= '0;
      pc_q     <= '0;
      imm_q    <= '0;
      res_q    <= '0;
      ready_q  <= 1'b1;
      brun_q   <= 1'b0;
      valid_q  <= 1'b0;
      pcsel_q  <= 1'b0;
      flush_q  <= 1'b0;
      bcnt_q   <= '0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_n;
      funct3_q <= funct3_n;
      pc_q     <= pc_n;
      imm_q    <= imm_n;
      res_q    <= res_n;
      ready_q  <= ready_n;
      brun_q   <= brun_n;
      valid_q  <= valid_n;
      pcsel_q  <= pcsel_n;
      flush_q  <= flush_n;
      bcnt_q   <= bcnt_n;
      tcnt_q   <= tcnt_n;
    end
  end

  assign bus.req_ready    = ready_q;
  assign bus.BrUn         = brun_q;
  assign bus.res_valid    = valid_q;
  assign bus.res_taken    = res_q.taken;
  assign bus.res_target   = res_q.target;
  assign bus.res_illegal  = res_q.illegal;
  assign bus.res_misalign = res_q.misalign;
  assign bus.PCSel        = pcsel_q;
  assign bus.flush        = flush_q;
  assign bus.branch_cnt   = bcnt_q;
  assign bus.taken_cnt    = tcnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed spec scenarios plus random
// branches checked against an operand-level model of RISC-V branch semantics.
module tb_branch_resolve;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CNT_MOD = 1 << CNT_W;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   exp_bcnt = 0;
  int   exp_tcnt = 0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;

  branch_resolve_if #(.CNT_W(CNT_W)) bus ();

  branch_resolve #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Comparator: honours BrUn on the current operands
  always_comb begin
    bus.BrEq = (op_a == op_b);
    bus.BrLT = bus.BrUn ? (op_a < op_b) : ($signed(op_a) < $signed(op_b));
  end

  function automatic bit model_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_target(input bit tk, input logic [31:0] pc, input logic [31:0] imm);
    logic [31:0] t;
    t = tk ? pc + imm : pc + 32'd4;
    return {t[31:1], 1'b0};
  endfunction

  function automatic logic [35:0] obs_res();
    return {bus.res_taken, bus.res_illegal, bus.res_misalign, bus.PCSel, bus.res_target};
  endfunction

  function automatic logic [2+2*CNT_W:0] obs_post();
    return {bus.res_valid, bus.req_ready, bus.flush, bus.branch_cnt, bus.taken_cnt};
  endfunction

  function automatic void model_count(input bit tk);
    exp_bcnt = (exp_bcnt + 1) % CNT_MOD;
    if (tk) exp_tcnt = (exp_tcnt + 1) % CNT_MOD;
  endfunction

  // Stimulus only: present a request from a negedge, return at the negedge of the CMP cycle
  task automatic issue(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] a, input logic [31:0] b,
                       output logic brun, output logic vld_cmp, output int acc_cyc, output bit ok);
    int n = 0;
    ok = 1'b0;
    brun = 1'b0;
    vld_cmp = 1'b0;
    acc_cyc = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.req_ready === 1'b1) begin
      bus.req_valid  = 1'b1;
      bus.req_funct3 = f3;
      bus.req_pc     = pc;
      bus.req_imm    = imm;
      op_a = a;
      op_b = b;
      @(negedge clk);
      bus.req_valid = 1'b0;
      brun    = bus.BrUn;
      vld_cmp = bus.res_valid;
      acc_cyc = cyc;
      ok = 1'b1;
    end
  endtask

  task automatic handshake(input int hold);
    repeat (hold) @(negedge clk);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_funct3 = '0; bus.req_pc = '0; bus.req_imm = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs_post() !== {1'b0, 1'b1, 1'b0, CNT_W'(0), CNT_W'(0)}) begin
      errors++; $display("FAIL reset_state got %h want %h", obs_post(), {1'b0, 1'b1, 1'b0, CNT_W'(0), CNT_W'(0)});
    end
    checks++;
    if ({bus.BrUn, bus.PCSel} !== 2'b00) begin
      errors++; $display("FAIL reset_brun_pcsel got %b want 00", {bus.BrUn, bus.PCSel});
    end
  endtask

  task automatic test_blt();
    logic brun, vc; int acc; bit ok;
    issue(3'b100, 32'h100, 32'h20, 32'hFFFF_FFFB, 32'h3, brun, vc, acc, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL blt_accept got timeout want accept"); return; end
    checks++;
    if ({brun, vc} !== 2'b00) begin errors++; $display("FAIL blt_cmp_brun_valid got %b want 00", {brun, vc}); end
    @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL blt_latency got res_valid=%b want 1", bus.res_valid); end
    checks++;
    if (obs_res() !== {1'b1, 1'b0, 1'b0, 1'b1, 32'h120}) begin
      errors++; $display("FAIL blt_result got %h want %h", obs_res(), {1'b1, 1'b0, 1'b0, 1'b1, 32'h120});
    end
    handshake(0);
    model_count(1'b1);
    checks++;
    if (obs_post() !== {1'b0, 1'b1, 1'b1, CNT_W'(1), CNT_W'(1)}) begin
      errors++; $display("FAIL blt_post got %h want %h", obs_post(), {1'b0, 1'b1, 1'b1, CNT_W'(1), CNT_W'(1)});
    end
    @(negedge clk);
    checks++;
    if (bus.flush !== 1'b0) begin errors++; $display("FAIL blt_flush_width got %b want 0", bus.flush); end
  endtask

  task automatic test_bgeu();
    logic brun, vc; int acc; bit ok;
    issue(3'b111, 32'h200, 32'h40, 32'h1, 32'hFFFF_FFFF, brun, vc, acc, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bgeu_accept got timeout want accept"); return; end
    checks++;
    if (brun !== 1'b1) begin errors++; $display("FAIL bgeu_brun got %b want 1", brun); end
    @(negedge clk);
    checks++;
    if (obs_res() !== {1'b0, 1'b0, 1'b0, 1'b0, 32'h204}) begin
      errors++; $display("FAIL bgeu_result got %h want %h", obs_res(), {1'b0, 1'b0, 1'b0, 1'b0, 32'h204});
    end
    handshake(1);
    model_count(1'b0);
    checks++;
    if (obs_post() !== {1'b0, 1'b1, 1'b0, CNT_W'(2), CNT_W'(1)}) begin
      errors++; $display("FAIL bgeu_post got %h want %h", obs_post(), {1'b0, 1'b1, 1'b0, CNT_W'(2), CNT_W'(1)});
    end
  endtask

  task automatic test_illegal();
    logic brun, vc; int acc; bit ok;
    issue(3'b010, 32'h300, 32'h8, 32'h5, 32'h5, brun, vc, acc, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL illegal_accept got timeout want accept"); return; end
    @(negedge clk);
    checks++;
    if (obs_res() !== {1'b0, 1'b1, 1'b0, 1'b0, 32'h304}) begin
      errors++; $display("FAIL illegal_result got %h want %h", obs_res(), {1'b0, 1'b1, 1'b0, 1'b0, 32'h304});
    end
    handshake(0);
    model_count(1'b0);
    checks++;
    if (obs_post() !== {1'b0, 1'b1, 1'b0, CNT_W'(3), CNT_W'(1)}) begin
      errors++; $display("FAIL illegal_post got %h want %h", obs_post(), {1'b0, 1'b1, 1'b0, CNT_W'(3), CNT_W'(1)});
    end
  endtask

  task automatic test_backpressure();
    logic brun, vc; int acc; bit ok, tk; logic [31:0] tgt;
    issue(3'b001, 32'h1000, 32'hFFFF_FFF6, 32'h7, 32'h9, brun, vc, acc, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_accept got timeout want accept"); return; end
    tk  = model_taken(3'b001, 32'h7, 32'h9);
    tgt = model_target(tk, 32'h1000, 32'hFFFF_FFF6);
    bus.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (obs_res() !== {tk, 1'b0, tk & tgt[1], tk, tgt}) begin
        errors++; $display("FAIL bp_hold_res[%0d] got %h want %h", i, obs_res(), {tk, 1'b0, tk & tgt[1], tk, tgt});
      end
      checks++;
      if (obs_post() !== {1'b1, 1'b0, 1'b0, CNT_W'(exp_bcnt), CNT_W'(exp_tcnt)}) begin
        errors++; $display("FAIL bp_hold_ctl[%0d] got %h want %h", i, obs_post(), {1'b1, 1'b0, 1'b0, CNT_W'(exp_bcnt), CNT_W'(exp_tcnt)});
      end
    end
    bus.req_valid = 1'b0;
    handshake(0);
    model_count(tk);
    checks++;
    if (obs_post() !== {1'b0, 1'b1, tk, CNT_W'(exp_bcnt), CNT_W'(exp_tcnt)}) begin
      errors++; $display("FAIL bp_post got %h want %h", obs_post(), {1'b0, 1'b1, tk, CNT_W'(exp_bcnt), CNT_W'(exp_tcnt)});
    end
  endtask

  task automatic test_back_to_back();
    logic brun, vc; int acc1, acc2; bit ok1, ok2;
    issue(3'b000, 32'h40, 32'h10, 32'h1, 32'h1, brun, vc, acc1, ok1);
    @(negedge clk);
    handshake(0);
    model_count(1'b1);
    issue(3'b110, 32'h80, 32'h10, 32'h3, 32'h2, brun, vc, acc2, ok2);
    checks++;
    if (!(ok1 && ok2) || (acc2 - acc1) !== 3) begin
      errors++; $display("FAIL b2b_spacing got %0d want 3", acc2 - acc1);
    end
    @(negedge clk);
    handshake(0);
    model_count(model_taken(3'b110, 32'h3, 32'h2));
    checks++;
    if (obs_post() !== {1'b0, 1'b1, 1'b0, CNT_W'(exp_bcnt), CNT_W'(exp_tcnt)}) begin
      errors++; $display("FAIL b2b_post got %h want %h", obs_post(), {1'b0, 1'b1, 1'b0, CNT_W'(exp_bcnt), CNT_W'(exp_tcnt)});
    end
  endtask

  task automatic test_random();
    logic brun, vc; int acc; bit ok, tk;
    logic [2:0] f3; logic [31:0] pc, imm, a, b, tgt;
    for (int n = 0; n < 40; n++) begin
      f3  = 3'($urandom_range(0, 7));
      pc  = $urandom();
      imm = $urandom();
      a   = $urandom();
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom();
      if ($urandom_range(0, 3) == 0) b = a ^ 32'h8000_0000;
      tk  = model_taken(f3, a, b);
      tgt = model_target(tk, pc, imm);
      issue(f3, pc, imm, a, b, brun, vc, acc, ok);
      checks++;
      if (!ok || brun !== f3[1] || vc !== 1'b0) begin
        errors++; $display("FAIL rnd_cmp[%0d] got ok=%b brun=%b valid=%b want ok=1 brun=%b valid=0", n, ok, brun, vc, f3[1]);
      end
      @(negedge clk);
      checks++;
      if (bus.res_valid !== 1'b1 || obs_res() !== {tk, f3[2:1] == 2'b01, tk & tgt[1], tk, tgt}) begin
        errors++; $display("FAIL rnd_result[%0d] f3=%b got v=%b %h want v=1 %h", n, f3, bus.res_valid, obs_res(), {tk, f3[2:1] == 2'b01, tk & tgt[1], tk, tgt});
      end
      handshake($urandom_range(0, 3));
      model_count(tk);
      checks++;
      if (obs_post() !== {1'b0, 1'b1, tk, CNT_W'(exp_bcnt), CNT_W'(exp_tcnt)}) begin
        errors++; $display("FAIL rnd_post[%0d] got %h want %h", n, obs_post(), {1'b0, 1'b1, tk, CNT_W'(exp_bcnt), CNT_W'(exp_tcnt)});
      end
    end
  endtask

  task automatic test_rst_in_resp();
    logic brun, vc; int acc; bit ok;
    issue(3'b000, 32'h500, 32'h20, 32'h9, 32'h9, brun, vc, acc, ok);
    @(negedge clk);
    rst = 1'b1;
    bus.res_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.res_ready = 1'b0;
    exp_bcnt = 0;
    exp_tcnt = 0;
    checks++;
    if (obs_post() !== {1'b0, 1'b1, 1'b0, CNT_W'(0), CNT_W'(0)} || bus.PCSel !== 1'b0) begin
      errors++; $display("FAIL rst_resp got %h pcsel=%b want %h pcsel=0", obs_post(), bus.PCSel, {1'b0, 1'b1, 1'b0, CNT_W'(0), CNT_W'(0)});
    end
    @(negedge clk);
    checks++;
    if (obs_post() !== {1'b0, 1'b1, 1'b0, CNT_W'(0), CNT_W'(0)}) begin
      errors++; $display("FAIL rst_resp_after got %h want %h", obs_post(), {1'b0, 1'b1, 1'b0, CNT_W'(0), CNT_W'(0)});
    end
  endtask

  task automatic test_wrap();
    logic brun, vc; int acc; bit ok; logic [31:0] v;
    issue(3'b000, 32'hFFFF_FFF0, 32'h20, 32'h1234, 32'h1234, brun, vc, acc, ok);
    @(negedge clk);
    checks++;
    if (obs_res() !== {1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0010}) begin
      errors++; $display("FAIL wrap_target got %h want %h", obs_res(), {1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0010});
    end
    handshake(0);
    model_count(1'b1);
    for (int n = 0; n < int'(CNT_MOD); n++) begin
      v = $urandom();
      issue(3'b000, $urandom(), 32'h8, v, v, brun, vc, acc, ok);
      @(negedge clk);
      handshake(0);
      model_count(1'b1);
      checks++;
      if (obs_post() !== {1'b0, 1'b1, 1'b1, CNT_W'(exp_bcnt), CNT_W'(exp_tcnt)}) begin
        errors++; $display("FAIL wrap_cnt[%0d] got %h want %h", n, obs_post(), {1'b0, 1'b1, 1'b1, CNT_W'(exp_bcnt), CNT_W'(exp_tcnt)});
      end
    end
  endtask

  initial begin
    test_reset();
    test_blt();
    test_bgeu();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_rst_in_resp();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog got timeout want completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
